store_buffer: RTL

- Queues committed stores in order and drains them to the TCM store-buffer write port.
- Drains at most one store per cycle, in program order.
- Forwards buffered store bytes to younger loads, byte-wise, so loads see pending stores before those stores reach the TCM.
- Sits between the commit stage and the bus/TCM write port.

---
 rtl/store_buffer_if.sv | 46 ++++
 rtl/store_buffer.sv | 115 +++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Handshake bundle between the store buffer and its commit, bus and LSU neighbours.
// The slave modport is the store buffer's view; the master modport is the environment's view.
interface store_buffer_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int SIZE_WIDTH     = 2,
  parameter int REG_DATA_WIDTH = 32
);
  logic                      commit_stbuf_valid;
  logic [ADDR_WIDTH-1:0]     commit_stbuf_addr;
  logic [SIZE_WIDTH-1:0]     commit_stbuf_size;
  logic [REG_DATA_WIDTH-1:0] commit_stbuf_data;
  logic                      stbuf_commit_ready;

  logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size;
  logic [REG_DATA_WIDTH-1:0] stbuf_bus_write_data;
  logic                      stbuf_bus_wr;
  logic                      bus_stbuf_write_ready;

  logic [ADDR_WIDTH-1:0]     lsu_stbuf_addr;
  logic [SIZE_WIDTH-1:0]     lsu_stbuf_size;
  logic [REG_DATA_WIDTH-1:0] stbuf_lsu_data;
  logic [3:0]                stbuf_lsu_mask;

  logic                      stbuf_empty;

  modport slave (
    input  commit_stbuf_valid, commit_stbuf_addr, commit_stbuf_size, commit_stbuf_data,
    output stbuf_commit_ready,
    output stbuf_bus_write_addr, stbuf_bus_write_size, stbuf_bus_write_data, stbuf_bus_wr,
    input  bus_stbuf_write_ready,
    input  lsu_stbuf_addr, lsu_stbuf_size,
    output stbuf_lsu_data, stbuf_lsu_mask,
    output stbuf_empty
  );

  modport master (
    output commit_stbuf_valid, commit_stbuf_addr, commit_stbuf_size, commit_stbuf_data,
    input  stbuf_commit_ready,
    input  stbuf_bus_write_addr, stbuf_bus_write_size, stbuf_bus_write_data, stbuf_bus_wr,
    output bus_stbuf_write_ready,
    output lsu_stbuf_addr, lsu_stbuf_size,
    input  stbuf_lsu_data, stbuf_lsu_mask,
    input  stbuf_empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: queues committed stores, drains one per cycle to the TCM
// write port, and forwards pending store bytes to younger loads.
module store_buffer #(
  parameter int DEPTH          = 4,
  parameter int PTR_WIDTH      = $clog2(DEPTH),
  parameter int ADDR_WIDTH     = 32,
  parameter int SIZE_WIDTH     = 2,
  parameter int REG_DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);

  localparam int LANES = 4;

  typedef logic [PTR_WIDTH:0] ptr_t;

  ptr_t                      head;
  ptr_t                      tail;
  logic [PTR_WIDTH-1:0]      head_idx;
  logic [PTR_WIDTH-1:0]      tail_idx;
  logic [DEPTH-1:0]          entry_valid;
  logic [ADDR_WIDTH-1:0]     entry_addr [DEPTH];
  logic [SIZE_WIDTH-1:0]     entry_size [DEPTH];
  logic [REG_DATA_WIDTH-1:0] entry_data [DEPTH];

  logic full;
  logic empty;
  logic enq;
  logic deq;

  logic [ADDR_WIDTH-1:0]     byte_addr;
  logic [ADDR_WIDTH-1:0]     offset;
  logic [PTR_WIDTH-1:0]      scan_idx;
  logic [4:0]                lane_sel;
  logic [REG_DATA_WIDTH-1:0] fwd_data;
  logic [LANES-1:0]          fwd_mask;

  assign head_idx = head[PTR_WIDTH-1:0];
  assign tail_idx = tail[PTR_WIDTH-1:0];

  // Same index with differing wrap bits means the tail has lapped the head.
  assign full  = (head[PTR_WIDTH] != tail[PTR_WIDTH]) && (head_idx == tail_idx);
  assign empty = (head == tail);
  assign enq   = sb.commit_stbuf_valid && !full;
  assign deq   = !empty && sb.bus_stbuf_write_ready;

  assign sb.stbuf_commit_ready   = !full;
  assign sb.stbuf_empty          = empty;
  assign sb.stbuf_bus_wr         = !empty;
  assign sb.stbuf_bus_write_addr = empty ? '0 : entry_addr[head_idx];
  assign sb.stbuf_bus_write_size = empty ? '0 : entry_size[head_idx];
  assign sb.stbuf_bus_write_data = empty ? '0 : entry_data[head_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      entry_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        entry_addr[k] <= '0;
        entry_size[k] <= '0;
        entry_data[k] <= '0;
      end
    end else begin
      if (enq) begin
        entry_addr[tail_idx]  <= sb.commit_stbuf_addr;
        entry_size[tail_idx]  <= sb.commit_stbuf_size;
        entry_data[tail_idx]  <= sb.commit_stbuf_data;
        entry_valid[tail_idx] <= 1'b1;
        tail                  <= tail + ptr_t'(1);
      end
      if (deq) begin
        entry_valid[head_idx] <= 1'b0;
        head                  <= head + ptr_t'(1);
      end
    end
  end

  // Entries are scanned oldest to youngest so a younger covering store overwrites the lane.
  always_comb begin
    fwd_data  = '0;
    fwd_mask  = '0;
    byte_addr = '0;
    offset    = '0;
    scan_idx  = '0;
    lane_sel  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < (1 << sb.lsu_stbuf_size)) begin
        byte_addr = sb.lsu_stbuf_addr + ADDR_WIDTH'(i);
        for (int k = 0; k < DEPTH; k++) begin
          scan_idx = head_idx + PTR_WIDTH'(k);
          offset   = byte_addr - entry_addr[scan_idx];
          lane_sel = {offset[1:0], 3'b000};
          if (entry_valid[scan_idx] &&
              (offset < (ADDR_WIDTH'(1) << entry_size[scan_idx]))) begin
            fwd_mask[i]        = 1'b1;
            fwd_data[8*i +: 8] = entry_data[scan_idx][lane_sel +: 8];
          end
        end
      end
    end
  end

  assign sb.stbuf_lsu_data = fwd_data;
  assign sb.stbuf_lsu_mask = fwd_mask;

  commit_size_legal: assert property (@(posedge clk) disable iff (!rst)
    sb.commit_stbuf_valid |-> (sb.commit_stbuf_size != {SIZE_WIDTH{1'b1}}));

  lsu_size_legal: assert property (@(posedge clk) disable iff (!rst)
    sb.lsu_stbuf_size != {SIZE_WIDTH{1'b1}});

endmodule
